// File: rtl/io_seg_scan.sv
// Multiplexed N-digit 7-segment scanner with hex/raw modes, PWM brightness, blink/blank and frame-synchronous loads.
// Outputs are registered one cycle after the internal pre/idx state; load never stalls, it is held pending until the frame boundary.
module io_seg_scan #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  mode,
    input  logic [DIGITS*4-1:0]   data_hex,
    input  logic [DIGITS*8-1:0]   data_raw,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic [DIGITS-1:0]     blank,
    input  logic [2:0]            bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_start
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int CW = PW + 4;

    logic [PW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         frames;
    logic                  phase;
    logic                  pending;

    logic                  mode_s;
    logic [DIGITS*4-1:0]   hex_s;
    logic [DIGITS*8-1:0]   raw_s;
    logic [DIGITS-1:0]     dp_s;
    logic [DIGITS-1:0]     blink_s;
    logic [DIGITS-1:0]     blank_s;

    logic                  tick;
    logic                  wrap;
    logic [3:0]            nib;
    logic [7:0]            raw_byte;
    logic [CW-1:0]         pwm_pos;
    logic [CW-1:0]         pwm_lim;
    logic                  on;
    logic                  dark;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign tick = (pre == PW'(SCAN_DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            idx    <= '0;
            frames <= '0;
            phase  <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
            if (wrap) begin
                if (frames == FW'(BLINK_FRAMES - 1)) begin
                    frames <= '0;
                    phase  <= ~phase;
                end else begin
                    frames <= frames + 1'b1;
                end
            end
        end
    end

    // Shadow copies only change on the frame wrap so a frame is never torn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
            mode_s  <= 1'b0;
            hex_s   <= '0;
            raw_s   <= '0;
            dp_s    <= '0;
            blink_s <= '0;
            blank_s <= '0;
        end else if (wrap) begin
            if (pending || load) begin
                mode_s  <= mode;
                hex_s   <= data_hex;
                raw_s   <= data_raw;
                dp_s    <= dp;
                blink_s <= blink;
                blank_s <= blank;
            end
            pending <= 1'b0;
        end else if (load) begin
            pending <= 1'b1;
        end
    end

    always_comb begin
        nib      = hex_s[{idx, 2'b00} +: 4];
        raw_byte = raw_s[{idx, 3'b000} +: 8];
        pwm_pos  = CW'({pre, 3'b000});
        pwm_lim  = (CW'(bright) + CW'(1)) * CW'(SCAN_DIV);
        on       = (pwm_pos < pwm_lim);
        dark     = !on || blank_s[idx] || (blink_s[idx] && phase);
    end

    // frame_start is taken from the first state of digit 0 so it lands with that digit's first output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= '1;
            seg         <= 8'hFF;
            frame_start <= 1'b0;
        end else begin
            an          <= dark ? '1 : ~(DIGITS'(1) << idx);
            seg         <= dark ? 8'hFF : (mode_s ? raw_byte : {~dp_s[idx], hex7(nib)});
            frame_start <= (pre == '0) && (idx == '0);
        end
    end

endmodule
